id_ex_decoder: RTL

- Decode/issue stage that drives the core's ALU. Accepts a fetched RV32I instruction with its PC and register-file read data, and produces the ALU control fields (funct7, funct3) and operands (A, B).
- Also produces writeback and branch sideband: rd, reg_write, branch condition.
- Output is registered through a 2-entry skid buffer with valid/ready on both sides, so in_ready is a registered signal and no combinational path runs from out_ready to in_ready.

---
 rtl/rv_decode_pkg.sv | 32 +++
 rtl/skid_buffer2.sv | 88 ++++++++
 rtl/id_ex_decoder.sv | 126 ++++++++++++
 3 files changed

// File: rtl/rv_decode_pkg.sv
// Shared RV32I decode constants and the decoded ALU/writeback bundle.
// With ILLEGAL_TRAP_EN defined the bundle carries an extra illegal flag.
package rv_decode_pkg;

  localparam int unsigned RV_XLEN = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [6:0]         funct7;
    logic [2:0]         funct3;
    logic [RV_XLEN-1:0] a;
    logic [RV_XLEN-1:0] b;
    logic [4:0]         rd;
    logic               reg_write;
    logic               is_branch;
    logic [2:0]         branch_cond;
`ifdef ILLEGAL_TRAP_EN
    logic               illegal;
`endif
  } bundle_t;

  localparam int unsigned BUNDLE_W = $bits(bundle_t);

endpackage

// File: rtl/skid_buffer2.sv
// Generic 2-entry valid/ready buffer. in_ready_o is a flop, so there is no
// combinational path from out_ready_i to in_ready_o.
module skid_buffer2 #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] out_data_o
);

  if (Depth != 2) begin : g_bad_depth
    $error("skid_buffer2 supports Depth == 2 only");
  end

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e           state_q, state_d;
  logic [Width-1:0] head_q, head_d;
  logic [Width-1:0] tail_q, tail_d;
  logic             in_ready_q, in_ready_d;
  logic             push, pop;

  assign out_valid_o = (state_q != StEmpty);
  assign in_ready_o  = in_ready_q;
  assign out_data_o  = head_q;
  assign push        = in_valid_i & in_ready_q;
  assign pop         = out_valid_o & out_ready_i;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    // flush also swallows a same-cycle push
    if (flush_i) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (push) begin
            head_d  = in_data_i;
            state_d = StOne;
          end
        end
        StOne: begin
          unique case ({push, pop})
            2'b11: head_d = in_data_i;
            2'b10: begin
              tail_d  = in_data_i;
              state_d = StFull;
            end
            2'b01: state_d = StEmpty;
            default: ;
          endcase
        end
        StFull: begin
          if (pop) begin
            head_d  = tail_q;
            state_d = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
    in_ready_d = (state_d != StFull);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StEmpty;
      head_q     <= '0;
      tail_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      in_ready_q <= in_ready_d;
    end
  end

endmodule

// File: rtl/id_ex_decoder.sv
// RV32I decode/issue stage: combinational decode into a 2-entry skid buffer.
// Define ILLEGAL_TRAP_EN to flag unsupported encodings on the illegal port.
module id_ex_decoder
  import rv_decode_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [6:0]      alu_funct7,
  output logic [2:0]      alu_funct3,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [4:0]      rd,
  output logic            reg_write,
  output logic            is_branch,
  output logic [2:0]      branch_cond,
  output logic            illegal
);

  if (XLEN != RV_XLEN) begin : g_bad_xlen
    $error("id_ex_decoder supports XLEN == 32 only");
  end

  bundle_t         dec;
  bundle_t         out_q;
  logic            legal;
  logic            rw;
  logic [2:0]      f3;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;

  assign f3    = instr[14:12];
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_u = {instr[31:12], 12'b0};

  always_comb begin
    dec   = '0;
    legal = 1'b1;
    rw    = 1'b0;
    unique case (instr[6:0])
      OPC_OP: begin
        dec.funct7 = instr[31:25];
        dec.funct3 = f3;
        dec.a      = rs1_data;
        dec.b      = rs2_data;
        rw         = 1'b1;
`ifdef ILLEGAL_TRAP_EN
        if (instr[31:25] != FUNCT7_BASE && instr[31:25] != FUNCT7_ALT) legal = 1'b0;
`endif
      end
      OPC_OP_IMM: begin
        dec.funct3 = f3;
        dec.a      = rs1_data;
        // shift immediates carry only the shamt; bit 30 is the SRAI selector
        if (f3 == 3'b001 || f3 == 3'b101) dec.b = {27'b0, instr[24:20]};
        else                              dec.b = imm_i;
        dec.funct7 = (f3 == 3'b101 && instr[30]) ? FUNCT7_ALT : FUNCT7_BASE;
        rw         = 1'b1;
      end
      OPC_LUI: begin
        dec.b = imm_u;
        rw    = 1'b1;
      end
      OPC_AUIPC: begin
        dec.a = pc;
        dec.b = imm_u;
        rw    = 1'b1;
      end
      OPC_BRANCH: begin
        dec.a           = rs1_data;
        dec.b           = rs2_data;
        dec.funct7      = FUNCT7_ALT;
        dec.is_branch   = 1'b1;
        dec.branch_cond = f3;
      end
      default: legal = 1'b0;
    endcase
    dec.rd        = instr[11:7];
    dec.reg_write = rw & (instr[11:7] != 5'd0);
    if (!legal) dec = '0;
`ifdef ILLEGAL_TRAP_EN
    dec.illegal = ~legal;
`endif
  end

  skid_buffer2 #(
    .Width (BUNDLE_W),
    .Depth (DEPTH)
  ) u_skid (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (dec),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_q)
  );

  assign alu_funct7  = out_q.funct7;
  assign alu_funct3  = out_q.funct3;
  assign alu_a       = out_q.a;
  assign alu_b       = out_q.b;
  assign rd          = out_q.rd;
  assign reg_write   = out_q.reg_write;
  assign is_branch   = out_q.is_branch;
  assign branch_cond = out_q.branch_cond;
`ifdef ILLEGAL_TRAP_EN
  assign illegal     = out_q.illegal;
`else
  assign illegal     = 1'b0;
`endif

endmodule
